// File: rtl/seg7_shift_display_pkg.sv
// Shared state encoding and segment patterns for the serial seven-segment driver.
// Pattern byte layout is {dp, g, f, e, d, c, b, a}; a is bit 0.
package seg7_shift_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Indexed by nibble value; entry 15 is listed first.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [7:0] seg_lookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_shift_display_hex.sv
// Hex nibble to segment pattern; dp (bit 7) is always 0 here.
// Purely combinational.
module hex_to_7seg
  import seg7_shift_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = seg_lookup(nibble);

endmodule

// File: rtl/seg7_shift_display.sv
// Serialises a multi-digit seven-segment frame into a 74HC595-style chain, then latches it.
// Frame takes 1 + 2*HALF_PERIOD*NBITS + HALF_PERIOD cycles; requests are accepted only while idle.
module seg7_shift_display
  import seg7_shift_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int HALF_PERIOD = 1,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    CLK,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
  output logic                    o_ds,
  output logic                    o_sclk,
  output logic                    o_latch,
  output logic                    o_done
);

  localparam int NBITS = 8 * NUM_DIGITS;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int HP_W  = $clog2(HALF_PERIOD + 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  state_t                   state_q, state_d;
  logic [4*NUM_DIGITS-1:0]  digits_q;
  logic [NUM_DIGITS-1:0]    dp_q;
  logic                     blank_lz_q;
  logic [NBITS-1:0]         frame_q, frame_d;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [HP_W-1:0]          hp_cnt_q;
  logic                     done_q;
  logic [NUM_DIGITS-1:0][7:0] seg_raw;
  logic                     lead;
  logic [7:0]               seg_k;
  logic                     accept, hp_end, last_bit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_to_7seg u_hex (
      .nibble(digits_q[4*g +: 4]),
      .seg   (seg_raw[g])
    );
  end

  // Leading zeros are blanked from the top digit down; digit 0 always shows.
  always_comb begin
    frame_d = '0;
    lead    = blank_lz_q;
    seg_k   = SEG_BLANK;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (lead && (k > 0) && (digits_q[4*k +: 4] == 4'h0)) begin
        seg_k = SEG_BLANK;
      end else begin
        lead  = 1'b0;
        seg_k = seg_raw[k];
      end
      seg_k = seg_k | {dp_q[k], 7'b0};
      if (ACTIVE_LOW) begin
        seg_k = ~seg_k;
      end
      frame_d[8*k +: 8] = seg_k;
    end
  end

  assign hp_end   = (hp_cnt_q == HP_LAST);
  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign accept   = (state_q == ST_IDLE) && i_valid;
  assign o_done   = done_q;

  always_ff @(posedge CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_sclk  = 1'b0;
    o_latch = 1'b0;
    o_ds    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: begin
        o_ds = frame_q[NBITS-1];
        if (hp_end) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        o_sclk = 1'b1;
        o_ds   = frame_q[NBITS-1];
        if (hp_end) state_d = last_bit ? ST_LATCH : ST_SHIFT_LO;
      end
      ST_LATCH: begin
        o_latch = 1'b1;
        if (hp_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge i_reset) begin
    if (i_reset) begin
      digits_q   <= '0;
      dp_q       <= '0;
      blank_lz_q <= 1'b0;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      hp_cnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == ST_LATCH) && hp_end;
      if (accept) begin
        digits_q   <= i_digits;
        dp_q       <= i_dp;
        blank_lz_q <= i_blank_lz;
      end
      case (state_q)
        ST_LOAD: begin
          frame_q   <= frame_d;
          bit_cnt_q <= '0;
          hp_cnt_q  <= '0;
        end
        ST_SHIFT_LO, ST_LATCH: begin
          hp_cnt_q <= hp_end ? '0 : hp_cnt_q + HP_W'(1);
        end
        ST_SHIFT_HI: begin
          if (hp_end) begin
            hp_cnt_q  <= '0;
            frame_q   <= {frame_q[NBITS-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end else begin
            hp_cnt_q <= hp_cnt_q + HP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_shift_display.sv
// Three drivers (plain, active-low, HALF_PERIOD=3) share one stimulus stream;
// a timeline model predicts every output cycle by cycle.
module tb_seg7_shift_display;

  localparam int NB = 16;

  logic       CLK = 1'b0;
  logic       i_reset, i_valid, i_blank_lz;
  logic [7:0] i_digits;
  logic [1:0] i_dp;
  logic [2:0] rdy, ds_w, sclk_w, latch_w, done_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  seg7_shift_display #(.NUM_DIGITS(2), .HALF_PERIOD(1), .ACTIVE_LOW(1'b0)) u_dut0 (
    .CLK(CLK), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rdy[0]),
    .i_digits(i_digits), .i_dp(i_dp), .i_blank_lz(i_blank_lz),
    .o_ds(ds_w[0]), .o_sclk(sclk_w[0]), .o_latch(latch_w[0]), .o_done(done_w[0]));

  seg7_shift_display #(.NUM_DIGITS(2), .HALF_PERIOD(1), .ACTIVE_LOW(1'b1)) u_dut1 (
    .CLK(CLK), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rdy[1]),
    .i_digits(i_digits), .i_dp(i_dp), .i_blank_lz(i_blank_lz),
    .o_ds(ds_w[1]), .o_sclk(sclk_w[1]), .o_latch(latch_w[1]), .o_done(done_w[1]));

  seg7_shift_display #(.NUM_DIGITS(2), .HALF_PERIOD(3), .ACTIVE_LOW(1'b0)) u_dut2 (
    .CLK(CLK), .i_reset(i_reset), .i_valid(i_valid), .o_ready(rdy[2]),
    .i_digits(i_digits), .i_dp(i_dp), .i_blank_lz(i_blank_lz),
    .o_ds(ds_w[2]), .o_sclk(sclk_w[2]), .o_latch(latch_w[2]), .o_done(done_w[2]));

  localparam logic [7:0] TB_SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int hp_of [3] = '{1, 1, 3};
  bit al_of [3] = '{1'b0, 1'b1, 1'b0};

  // Model state: edge count, per-DUT accepted edge and expected frame.
  int          edge_n = 0;
  bit          have [3];
  int          t0 [3];
  logic [15:0] frm [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as shifted: digit 1 in the high byte, MSB goes out first.
  function automatic logic [15:0] build(input logic [7:0] dig, input logic [1:0] dp,
                                        input logic blz, input bit al);
    logic [15:0] f;
    logic [7:0]  b;
    logic [3:0]  nib;
    bit          lead;
    f    = '0;
    lead = blz;
    for (int k = 1; k >= 0; k--) begin
      nib = dig[4*k +: 4];
      b   = TB_SEG[nib];
      if (lead && k != 0 && nib == 4'h0) b = 8'h00;
      else lead = 1'b0;
      b[7] = dp[k];
      if (al) b = ~b;
      f[8*k +: 8] = b;
    end
    return f;
  endfunction

  // Returns {ds, sclk, latch, ready, done} expected after the current edge.
  function automatic logic [4:0] exp_out(input int d);
    int o, hp, len, p;
    logic e_ds, e_sclk, e_lat, e_rdy, e_done;
    hp  = hp_of[d];
    len = 1 + 2 * hp * NB + hp;
    o   = edge_n - t0[d];
    e_ds = 1'b0; e_sclk = 1'b0; e_lat = 1'b0; e_rdy = 1'b1; e_done = 1'b0;
    if (have[d] && o < len) begin
      e_rdy = 1'b0;
      if (o >= 1 && o <= 2 * hp * NB) begin
        p      = (o - 1) / hp;
        e_sclk = ((p % 2) == 1);
        e_ds   = frm[d][NB - 1 - p / 2];
      end else if (o > 2 * hp * NB) begin
        e_lat = 1'b1;
      end
    end
    if (have[d] && o == len) e_done = 1'b1;
    return {e_ds, e_sclk, e_lat, e_rdy, e_done};
  endfunction

  initial begin : model
    bit acc [3];
    logic [4:0] e;
    for (int d = 0; d < 3; d++) have[d] = 1'b0;
    forever begin
      @(posedge CLK);
      for (int d = 0; d < 3; d++) begin
        e = exp_out(d);
        acc[d] = !i_reset && i_valid && e[1];
      end
      edge_n++;
      for (int d = 0; d < 3; d++) begin
        if (i_reset) have[d] = 1'b0;
        else if (acc[d]) begin
          have[d] = 1'b1;
          t0[d]   = edge_n;
          frm[d]  = build(i_digits, i_dp, i_blank_lz, al_of[d]);
        end
      end
    end
  end

  initial begin : compare
    logic [4:0] e;
    forever begin
      @(negedge CLK);
      for (int d = 0; d < 3; d++) begin
        e = exp_out(d);
        check($sformatf("d%0d_ds", d),    32'(ds_w[d]),    32'(e[4]));
        check($sformatf("d%0d_sclk", d),  32'(sclk_w[d]),  32'(e[3]));
        check($sformatf("d%0d_latch", d), 32'(latch_w[d]), 32'(e[2]));
        check($sformatf("d%0d_ready", d), 32'(rdy[d]),     32'(e[1]));
        check($sformatf("d%0d_done", d),  32'(done_w[d]),  32'(e[0]));
      end
    end
  end

  task automatic wait_all_ready();
    int n;
    n = 0;
    while (rdy !== 3'b111) begin
      if (n == 1000) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout: ready=%b, expected 111", rdy);
        break;
      end
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic send(input logic [7:0] dig, input logic [1:0] dp, input logic blz);
    wait_all_ready();
    i_digits   = dig;
    i_dp       = dp;
    i_blank_lz = blz;
    i_valid    = 1'b1;
    @(negedge CLK);
    i_valid = 1'b0;
  endtask

  task automatic check_idle_now(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_d%0d_ds", tag, d),    32'(ds_w[d]),    32'd0);
      check($sformatf("%s_d%0d_sclk", tag, d),  32'(sclk_w[d]),  32'd0);
      check($sformatf("%s_d%0d_latch", tag, d), 32'(latch_w[d]), 32'd0);
      check($sformatf("%s_d%0d_done", tag, d),  32'(done_w[d]),  32'd0);
      check($sformatf("%s_d%0d_ready", tag, d), 32'(rdy[d]),     32'd1);
    end
  endtask

  // Called at the first negedge after the accepting edge (offset 0).
  task automatic measure();
    logic [15:0] bits = '0;
    logic prev = 1'b0;
    int nbits = 0, lat0 = 0, lat2 = 0, hi2 = 0, rdy_low0 = 0, lat1_ds = 0;
    int done0_at = -1, done2_at = -1;
    for (int n = 0; n <= 110; n++) begin
      if (sclk_w[0] && !prev) begin
        bits = {bits[14:0], ds_w[0]};
        nbits++;
      end
      prev = sclk_w[0];
      if (latch_w[0]) lat0++;
      if (latch_w[2]) lat2++;
      if (sclk_w[2]) hi2++;
      if (latch_w[1] && ds_w[1]) lat1_ds++;
      if (!rdy[0]) rdy_low0++;
      if (done_w[0] && done0_at < 0) done0_at = n;
      if (done_w[2] && done2_at < 0) done2_at = n;
      @(negedge CLK);
    end
    check("t2_bits", 32'(bits), 32'h063F);
    check("t2_rising_edges", 32'(nbits), 32'd16);
    check("t2_latch_cycles", 32'(lat0), 32'd1);
    check("t2_done_offset", 32'(done0_at), 32'd34);
    check("t2_ready_low_cycles", 32'(rdy_low0), 32'd34);
    check("t5_latch_cycles", 32'(lat2), 32'd3);
    check("t5_sclk_high_cycles", 32'(hi2), 32'd48);
    check("t5_done_offset", 32'(done2_at), 32'd100);
    check("t4_ds_in_latch", 32'(lat1_ds), 32'd0);
  endtask

  initial begin : stim
    i_reset = 1'b1; i_valid = 1'b0; i_digits = '0; i_dp = '0; i_blank_lz = 1'b0;

    check("model_10", 32'(build(8'h10, 2'b00, 1'b0, 1'b0)), 32'h063F);
    check("model_05_blz", 32'(build(8'h05, 2'b00, 1'b1, 1'b0)), 32'h006D);
    check("model_00_blz", 32'(build(8'h00, 2'b00, 1'b1, 1'b0)), 32'h003F);
    check("model_05", 32'(build(8'h05, 2'b00, 1'b0, 1'b0)), 32'h3F6D);
    check("model_88_al", 32'(build(8'h88, 2'b01, 1'b0, 1'b1)), 32'h8000);

    repeat (3) @(negedge CLK);
    check_idle_now("reset");
    i_reset = 1'b0;
    repeat (2) @(negedge CLK);

    send(8'h10, 2'b00, 1'b0);
    measure();

    // Reset mid-frame, during a shift-clock high phase of the fast drivers.
    send(8'h3C, 2'b11, 1'b0);
    repeat (10) @(negedge CLK);
    #2 i_reset = 1'b1;
    #1 check_idle_now("midreset");
    @(negedge CLK);
    @(negedge CLK);
    i_reset = 1'b0;
    repeat (5) @(negedge CLK);

    send(8'h05, 2'b00, 1'b1);
    send(8'h00, 2'b00, 1'b1);
    send(8'h05, 2'b00, 1'b0);
    send(8'h88, 2'b01, 1'b0);

    // Requests while busy must be dropped.
    send(8'h42, 2'b10, 1'b0);
    repeat (5) @(negedge CLK);
    i_digits = 8'hEE; i_dp = 2'b11; i_valid = 1'b1;
    @(negedge CLK);
    i_valid = 1'b0;
    repeat (3) begin
      i_digits = 8'($urandom);
      @(negedge CLK);
    end
    wait_all_ready();

    // Held request: back-to-back frames with data changing every cycle.
    i_valid = 1'b1; i_digits = 8'hA7; i_dp = 2'b01;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      i_digits   = 8'($urandom);
      i_dp       = 2'($urandom);
      i_blank_lz = 1'($urandom);
    end
    i_valid = 1'b0;
    wait_all_ready();

    for (int i = 0; i < 600; i++) begin
      i_valid    = ($urandom_range(0, 3) == 0);
      i_digits   = 8'($urandom);
      if ($urandom_range(0, 2) == 0) i_digits[7:4] = 4'h0;
      if ($urandom_range(0, 5) == 0) i_digits[3:0] = 4'h0;
      i_dp       = 2'($urandom);
      i_blank_lz = 1'($urandom);
      if (i == 300) begin
        #2 i_reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        i_reset = 1'b0;
      end
      @(negedge CLK);
    end
    i_valid = 1'b0;
    wait_all_ready();
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
